// File: rtl/player_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : player_ctrl_n
// Brief    : Per-frame player movement, jump physics, projectile damage,
//            invulnerability and life tracking for the side-scroller.
// Revision : 1.0  initial release
// ============================================================================
module player_ctrl_n #(
    parameter int         N_BULLETS     = 2,
    parameter int         W             = 20,
    parameter int         H             = 33,
    parameter int         X_STEP        = 5,
    parameter int         JUMP_V        = 16,
    parameter int         VY_MAX        = 15,
    parameter int         SCROLL_X      = 320,
    parameter int         PROGRESS_MAX  = 3200,
    parameter int         CHECKPOINT    = 2860,
    parameter int         CHECKPOINT_X  = 144,
    parameter int         RESPAWN_Y     = 100,
    parameter int         LIVES_MAX     = 3,
    parameter int         INVULN_FRAMES = 60,
    parameter logic [7:0] KEY_R         = 8'h07,
    parameter logic [7:0] KEY_L         = 8'h04,
    parameter logic [7:0] KEY_J         = 8'h1A
) (
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    enable,
    input  logic                    restart,
    input  logic [7:0]              keycode,
    input  logic [9:0]              ground_y,
    input  logic [10*N_BULLETS-1:0] bullet_x,
    input  logic [10*N_BULLETS-1:0] bullet_y,
    input  logic [N_BULLETS-1:0]    bullet_valid,
    output logic [9:0]              player_x,
    output logic [9:0]              player_y,
    output logic [11:0]             progress,
    output logic [2:0]              lives_lost,
    output logic                    direction,
    output logic                    scroll,
    output logic                    jumping,
    output logic                    hit,
    output logic                    invuln,
    output logic                    game_over
);

    localparam int          c_CNT_W       = $clog2(INVULN_FRAMES + 1);
    localparam logic [9:0]  c_X_START     = 10'd20;
    localparam logic [9:0]  c_X_MAX       = 10'(639 - W);
    localparam logic [9:0]  c_X_MIN       = 10'(W);
    localparam logic [9:0]  c_X_LEFT_TH   = 10'(W + X_STEP);
    localparam logic [9:0]  c_STEP10      = 10'(X_STEP);
    localparam logic [11:0] c_STEP12      = 12'(X_STEP);
    localparam logic [9:0]  c_SCROLL_X    = 10'(SCROLL_X);
    localparam logic [11:0] c_PROG_MAX    = 12'(PROGRESS_MAX);
    localparam logic [11:0] c_CKPT        = 12'(CHECKPOINT);
    localparam logic [9:0]  c_CKPT_X      = 10'(CHECKPOINT_X);
    localparam logic [9:0]  c_RESPAWN_Y   = 10'(RESPAWN_Y);
    localparam logic [9:0]  c_H10         = 10'(H);
    localparam logic [11:0] c_H12         = 12'(H);
    localparam logic [10:0] c_W11         = 11'(W);
    localparam logic [10:0] c_H11         = 11'(H);
    localparam logic [9:0]  c_JUMP_VY     = 10'(-JUMP_V);
    localparam logic [9:0]  c_VY_MAX      = 10'(VY_MAX);
    localparam logic [9:0]  c_Y_FALL      = 10'd479;
    localparam logic [2:0]  c_LIVES_MAX   = 3'(LIVES_MAX);
    localparam logic [c_CNT_W-1:0] c_INVULN = c_CNT_W'(INVULN_FRAMES);

    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic [9:0]         r_vy;
    logic [11:0]        r_prog;
    logic [2:0]         r_lives;
    logic               r_dir;
    logic               r_scroll;
    logic               r_jump;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N_BULLETS-1:0] w_hit_vec;
    logic                 w_game_over;

    // Differences are taken modulo 2048; bit 10 is the sign of an exact 11-bit result.
    generate
        for (genvar i = 0; i < N_BULLETS; i++) begin : g_hit
            logic [10:0] w_dx;
            logic [10:0] w_dy;
            logic [10:0] w_adx;
            logic [10:0] w_ady;
            assign w_dx  = {1'b0, bullet_x[10*i +: 10]} - {1'b0, r_x};
            assign w_dy  = {1'b0, bullet_y[10*i +: 10]} - {1'b0, r_y};
            assign w_adx = w_dx[10] ? (~w_dx + 11'd1) : w_dx;
            assign w_ady = w_dy[10] ? (~w_dy + 11'd1) : w_dy;
            assign w_hit_vec[i] = bullet_valid[i] && (w_adx <= c_W11) && (w_ady <= c_H11);
        end
    endgenerate

    assign hit         = |w_hit_vec;
    assign w_game_over = (r_lives == c_LIVES_MAX);

    logic               w_dir_n;
    logic               w_scroll_n;
    logic               w_jump_n;
    logic               w_fall;
    logic               w_dmg;
    logic [9:0]         w_x_mv;
    logic [9:0]         w_x_n;
    logic [9:0]         w_y_n;
    logic [9:0]         w_vy_n;
    logic [10:0]        w_x_sum;
    logic [11:0]        w_prog_sum;
    logic [11:0]        w_prog_n;
    logic [11:0]        w_feet;
    logic [c_CNT_W-1:0] w_cnt_n;
    logic [2:0]         w_lives_n;

    always_comb begin
        w_dir_n    = r_dir;
        w_scroll_n = 1'b0;
        w_jump_n   = r_jump;
        w_x_mv     = r_x;
        w_prog_n   = r_prog;
        w_vy_n     = r_vy;
        w_y_n      = r_y;
        w_x_n      = r_x;
        w_cnt_n    = r_cnt;
        w_lives_n  = r_lives;
        w_x_sum    = {1'b0, r_x} + {1'b0, c_STEP10};
        w_prog_sum = r_prog + c_STEP12;
        w_feet     = {2'b00, r_y} + c_H12;
        w_fall     = 1'b0;
        w_dmg      = 1'b0;

        if (keycode == KEY_R) begin
            w_dir_n = 1'b1;
        end else if (keycode == KEY_L) begin
            w_dir_n = 1'b0;
        end

        // Past SCROLL_X the world moves instead of the player, until the level ends.
        if (keycode == KEY_R) begin
            if ((r_x < c_SCROLL_X) || (r_prog >= c_PROG_MAX)) begin
                w_x_mv = (w_x_sum > {1'b0, c_X_MAX}) ? c_X_MAX : w_x_sum[9:0];
            end else begin
                w_prog_n   = (w_prog_sum > c_PROG_MAX) ? c_PROG_MAX : w_prog_sum;
                w_scroll_n = 1'b1;
            end
        end else if (keycode == KEY_L) begin
            w_x_mv = (r_x >= c_X_LEFT_TH) ? (r_x - c_STEP10) : c_X_MIN;
        end

        if ((keycode == KEY_J) && !r_jump && ((w_feet + 12'd2) > {2'b00, ground_y})) begin
            w_vy_n   = c_JUMP_VY;
            w_jump_n = 1'b1;
        end else begin
            w_vy_n = ($signed(r_vy) >= $signed(c_VY_MAX)) ? c_VY_MAX : (r_vy + 10'd1);
        end

        // The freshly computed speed is applied in the same frame.
        if (!w_vy_n[9] && ((w_feet + {2'b00, w_vy_n}) > {2'b00, ground_y})) begin
            w_y_n    = ground_y - c_H10;
            w_vy_n   = 10'd0;
            w_jump_n = 1'b0;
        end else begin
            w_y_n = r_y + w_vy_n;
        end

        // Values with bit 9 set are above the screen top, not below the floor.
        w_fall = (w_y_n > c_Y_FALL) && !w_y_n[9];
        w_dmg  = hit && (r_cnt == '0);

        if (w_fall) begin
            w_y_n  = c_RESPAWN_Y;
            w_vy_n = 10'd0;
            w_x_n  = (r_prog >= c_CKPT) ? c_CKPT_X : c_X_START;
        end else begin
            w_x_n  = w_x_mv;
        end

        if (w_dmg) begin
            w_cnt_n = c_INVULN;
        end else if (r_cnt != '0) begin
            w_cnt_n = r_cnt - c_CNT_W'(1);
        end

        if ((w_fall || w_dmg) && (r_lives != c_LIVES_MAX)) begin
            w_lives_n = r_lives + 3'd1;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_x      <= c_X_START;
            r_y      <= c_RESPAWN_Y;
            r_vy     <= 10'd0;
            r_prog   <= 12'd0;
            r_lives  <= 3'd0;
            r_dir    <= 1'b1;
            r_scroll <= 1'b0;
            r_jump   <= 1'b0;
            r_cnt    <= '0;
        end else if (restart) begin
            r_x      <= c_X_START;
            r_y      <= c_RESPAWN_Y;
            r_vy     <= 10'd0;
            r_prog   <= 12'd0;
            r_lives  <= 3'd0;
            r_dir    <= 1'b1;
            r_scroll <= 1'b0;
            r_jump   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_game_over || !enable) begin
            r_scroll <= 1'b0;
        end else begin
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_vy     <= w_vy_n;
            r_prog   <= w_prog_n;
            r_lives  <= w_lives_n;
            r_dir    <= w_dir_n;
            r_scroll <= w_scroll_n;
            r_jump   <= w_jump_n;
            r_cnt    <= w_cnt_n;
        end
    end

    assign player_x   = r_x;
    assign player_y   = r_y;
    assign progress   = r_prog;
    assign lives_lost = r_lives;
    assign direction  = r_dir;
    assign scroll     = r_scroll;
    assign jumping    = r_jump;
    assign invuln     = (r_cnt != '0);
    assign game_over  = w_game_over;

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ctrl_n
// Brief    : Directed and randomized frames for player_ctrl_n, compared each
//            frame against an integer reference model of the game rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_player_ctrl_n;

    localparam int         NB            = 2;
    localparam int         W             = 20;
    localparam int         H             = 33;
    localparam int         X_STEP        = 5;
    localparam int         JUMP_V        = 16;
    localparam int         VY_MAX        = 15;
    localparam int         SCROLL_X      = 320;
    localparam int         PROGRESS_MAX  = 3200;
    localparam int         CHECKPOINT    = 2860;
    localparam int         CHECKPOINT_X  = 144;
    localparam int         RESPAWN_Y     = 100;
    localparam int         LIVES_MAX     = 3;
    localparam int         INVULN_FRAMES = 60;
    localparam logic [7:0] KEY_R         = 8'h07;
    localparam logic [7:0] KEY_L         = 8'h04;
    localparam logic [7:0] KEY_J         = 8'h1A;

    logic             Reset;
    logic             frame_clk;
    logic             enable;
    logic             restart;
    logic [7:0]       keycode;
    logic [9:0]       ground_y;
    logic [10*NB-1:0] bullet_x;
    logic [10*NB-1:0] bullet_y;
    logic [NB-1:0]    bullet_valid;
    logic [9:0]       player_x;
    logic [9:0]       player_y;
    logic [11:0]      progress;
    logic [2:0]       lives_lost;
    logic             direction;
    logic             scroll;
    logic             jumping;
    logic             hit;
    logic             invuln;
    logic             game_over;

    player_ctrl_n dut (
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .enable       (enable),
        .restart      (restart),
        .keycode      (keycode),
        .ground_y     (ground_y),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .bullet_valid (bullet_valid),
        .player_x     (player_x),
        .player_y     (player_y),
        .progress     (progress),
        .lives_lost   (lives_lost),
        .direction    (direction),
        .scroll       (scroll),
        .jumping      (jumping),
        .hit          (hit),
        .invuln       (invuln),
        .game_over    (game_over)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_pass   = 0;

    int m_x, m_y, m_vy, m_prog, m_lives, m_cnt;
    bit m_dir, m_scroll, m_jump;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_x = 20; m_y = RESPAWN_Y; m_vy = 0; m_prog = 0; m_lives = 0; m_cnt = 0;
        m_dir = 1'b1; m_scroll = 1'b0; m_jump = 1'b0;
    endfunction

    function automatic bit model_hit();
        bit any = 1'b0;
        for (int i = 0; i < NB; i++) begin
            int bx = int'(bullet_x[10*i +: 10]);
            int by = int'(bullet_y[10*i +: 10]);
            int dx = (bx > m_x) ? bx - m_x : m_x - bx;
            int dy = (by > m_y) ? by - m_y : m_y - by;
            if (bullet_valid[i] && dx <= W && dy <= H) any = 1'b1;
        end
        return any;
    endfunction

    // One frame of the game rules in plain integer arithmetic.
    function automatic void model_step();
        int nx, ny, nvy, np, g;
        bit nj, fall, dmg;
        if (Reset || restart) begin
            model_reset();
            return;
        end
        m_scroll = 1'b0;
        if (m_lives == LIVES_MAX || !enable) return;
        g  = int'(ground_y);
        nx = m_x; np = m_prog; nj = m_jump;
        if (keycode == KEY_R) begin
            m_dir = 1'b1;
            if (m_x < SCROLL_X || m_prog >= PROGRESS_MAX) nx = imin(m_x + X_STEP, 639 - W);
            else begin
                np = imin(m_prog + X_STEP, PROGRESS_MAX);
                m_scroll = 1'b1;
            end
        end else if (keycode == KEY_L) begin
            m_dir = 1'b0;
            nx = (m_x >= W + X_STEP) ? m_x - X_STEP : W;
        end
        if (keycode == KEY_J && !m_jump && m_y + H + 2 > g) begin
            nvy = -JUMP_V; nj = 1'b1;
        end else begin
            nvy = imin(m_vy + 1, VY_MAX);
        end
        if (nvy >= 0 && m_y + H + nvy > g) begin
            ny = (g - H) & 1023; nvy = 0; nj = 1'b0;
        end else begin
            ny = (m_y + nvy) & 1023;
        end
        fall = (ny > 479) && (ny < 512);
        dmg  = model_hit() && (m_cnt == 0);
        if (fall) begin
            ny = RESPAWN_Y; nvy = 0;
            nx = (m_prog >= CHECKPOINT) ? CHECKPOINT_X : 20;
        end
        if (dmg) m_cnt = INVULN_FRAMES;
        else if (m_cnt > 0) m_cnt--;
        if ((fall || dmg) && m_lives < LIVES_MAX) m_lives++;
        m_x = nx; m_y = ny; m_vy = nvy; m_prog = np; m_jump = nj;
    endfunction

    task automatic check_outputs();
        chk("x",         int'(player_x),   m_x);
        chk("y",         int'(player_y),   m_y);
        chk("progress",  int'(progress),   m_prog);
        chk("lives",     int'(lives_lost), m_lives);
        chk("direction", int'(direction),  int'(m_dir));
        chk("scroll",    int'(scroll),     int'(m_scroll));
        chk("jumping",   int'(jumping),    int'(m_jump));
        chk("invuln",    int'(invuln),     int'(m_cnt != 0));
        chk("game_over", int'(game_over),  int'(m_lives == LIVES_MAX));
    endtask

    // Inputs are set just after an edge; hit is sampled mid-frame, state after the edge.
    task automatic tick();
        #1;
        chk("hit", int'(hit), int'(model_hit()));
        @(posedge frame_clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic wait_grounded(input int gy);
        for (int i = 0; i < 200 && !(m_y == gy && m_vy == 0 && !m_jump); i++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n, gx, gy;
        Reset = 1'b1; enable = 1'b0; restart = 1'b0; keycode = 8'h00; ground_y = 10'd400;
        bullet_x = '0; bullet_y = '0; bullet_valid = '0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        check_outputs();
        chk("rst_x", int'(player_x), 20);
        chk("rst_y", int'(player_y), 100);
        chk("rst_dir", int'(direction), 1);
        chk("rst_lives", int'(lives_lost), 0);

        // Walk right, then scroll, then run to the level end.
        Reset = 1'b0; enable = 1'b1; keycode = KEY_R;
        repeat (10) tick();
        chk("walk_x70", int'(player_x), 70);
        chk("walk_dir", int'(direction), 1);
        chk("walk_scroll", int'(scroll), 0);
        chk("walk_prog", int'(progress), 0);
        repeat (50) tick();
        chk("walk_x320", int'(player_x), 320);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("scroll_pulse", int'(scroll), 1);
            chk("scroll_x_held", int'(player_x), 320);
        end
        chk("scroll_prog20", int'(progress), 20);
        repeat (635) tick();
        chk("prog_3195", int'(progress), 3195);
        tick();
        chk("prog_sat", int'(progress), 3200);
        tick();
        chk("end_x325", int'(player_x), 325);
        chk("end_prog", int'(progress), 3200);
        chk("end_scroll", int'(scroll), 0);
        tick();
        repeat (58) tick();
        chk("clamp_right", int'(player_x), 619);
        keycode = KEY_L;
        tick();
        chk("left_dir", int'(direction), 0);
        chk("left_x", int'(player_x), 614);
        repeat (119) tick();
        chk("clamp_left", int'(player_x), 20);
        chk("left_prog_kept", int'(progress), 3200);

        keycode = 8'h00; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_x", int'(player_x), 20);
        chk("rs_prog", int'(progress), 0);
        chk("rs_dir", int'(direction), 1);

        // Jump from the ground and hold the key through the whole flight.
        wait_grounded(367);
        chk("grounded_y", int'(player_y), 367);
        keycode = KEY_J;
        tick();
        chk("jump_flag", int'(jumping), 1);
        n = 0;
        while (jumping && n < 100) begin
            tick();
            n++;
        end
        chk("air_ticks", n, 33);
        chk("land_y", int'(player_y), 367);
        keycode = 8'h00;
        tick();

        // Hitbox edge, damage, and immunity window.
        bullet_x = {10'(m_x + 21), 10'd0}; bullet_y = {10'(m_y), 10'd0}; bullet_valid = 2'b10;
        #1 chk("hit_miss_dx21", int'(hit), 0);
        tick();
        bullet_x = {10'(m_x + 20), 10'd0}; bullet_y = {10'(m_y - 33), 10'd0};
        #1 chk("hit_corner", int'(hit), 1);
        tick();
        chk("dmg_lives1", int'(lives_lost), 1);
        chk("dmg_invuln", int'(invuln), 1);
        repeat (59) tick();
        chk("immune_lives", int'(lives_lost), 1);
        chk("immune_still", int'(invuln), 1);
        tick();
        chk("immune_over", int'(invuln), 0);
        tick();
        chk("dmg_lives2", int'(lives_lost), 2);
        bullet_valid = '0; restart = 1'b1;
        tick();
        restart = 1'b0;

        // Fall-out past the checkpoint.
        keycode = KEY_R;
        repeat (640) tick();
        chk("ckpt_prog", int'(progress), 2900);
        keycode = 8'h00; ground_y = 10'd600;
        n = 0;
        while (lives_lost == 3'd0 && n < 100) begin tick(); n++; end
        chk("fall_ckpt_lives", int'(lives_lost), 1);
        chk("fall_ckpt_x", int'(player_x), 144);
        chk("fall_ckpt_y", int'(player_y), 100);

        // Fall-out before the checkpoint.
        restart = 1'b1; ground_y = 10'd400;
        tick();
        restart = 1'b0; keycode = KEY_R;
        repeat (80) tick();
        chk("early_prog", int'(progress), 100);
        keycode = 8'h00; ground_y = 10'd600;
        n = 0;
        while (lives_lost == 3'd0 && n < 100) begin tick(); n++; end
        chk("fall_early_x", int'(player_x), 20);
        chk("fall_early_lives", int'(lives_lost), 1);

        // Fall-out and damaging hit in the same frame.
        n = 0;
        while (lives_lost == 3'd1 && n < 100) begin
            if (m_y + imin(m_vy + 1, VY_MAX) > 479) begin
                bullet_x = {10'd0, 10'(m_x)}; bullet_y = {10'd0, 10'(m_y)}; bullet_valid = 2'b01;
            end else begin
                bullet_valid = '0;
            end
            tick();
            n++;
        end
        bullet_valid = '0;
        chk("fall_hit_lives", int'(lives_lost), 2);
        chk("fall_hit_invuln", int'(invuln), 1);

        // Third loss, frozen game, restart.
        n = 0;
        while (lives_lost == 3'd2 && n < 100) begin tick(); n++; end
        chk("go_lives", int'(lives_lost), 3);
        chk("go_flag", int'(game_over), 1);
        gx = m_x; gy = m_y;
        keycode = KEY_R;
        bullet_x = {10'd0, 10'(m_x)}; bullet_y = {10'd0, 10'(m_y)}; bullet_valid = 2'b01;
        repeat (5) tick();
        chk("go_frozen_x", int'(player_x), gx);
        chk("go_frozen_y", int'(player_y), gy);
        chk("go_lives_sat", int'(lives_lost), 3);
        bullet_valid = '0; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("go_restart_flag", int'(game_over), 0);
        chk("go_restart_lives", int'(lives_lost), 0);

        // enable low holds everything.
        ground_y = 10'd400; keycode = KEY_R; enable = 1'b0;
        gx = m_x; gy = m_y;
        repeat (3) tick();
        chk("hold_x", int'(player_x), gx);
        chk("hold_y", int'(player_y), gy);
        chk("hold_scroll", int'(scroll), 0);
        enable = 1'b1; keycode = 8'h00;

        // Asynchronous reset mid-jump and mid-immunity.
        wait_grounded(367);
        bullet_x = {10'd0, 10'(m_x)}; bullet_y = {10'd0, 10'(m_y)}; bullet_valid = 2'b01;
        tick();
        bullet_valid = '0; keycode = KEY_J;
        tick();
        tick();
        chk("pre_arst_jump", int'(jumping), 1);
        chk("pre_arst_inv", int'(invuln), 1);
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("arst_y", int'(player_y), 100);
        chk("arst_jump", int'(jumping), 0);
        chk("arst_inv", int'(invuln), 0);
        tick();
        Reset = 1'b0; keycode = 8'h00;

        // Randomized frames against the model.
        for (int c = 0; c < 1500; c++) begin
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 4))
                0:       keycode = KEY_R;
                1:       keycode = KEY_L;
                2:       keycode = KEY_J;
                3:       keycode = 8'h00;
                default: keycode = 8'($urandom);
            endcase
            if ($urandom_range(0, 39) == 0)
                ground_y = ($urandom_range(0, 5) == 0) ? 10'd600 : 10'($urandom_range(250, 470));
            for (int ch = 0; ch < NB; ch++) begin
                int rx = int'($urandom_range(0, 50));
                int ry = int'($urandom_range(0, 80));
                bullet_valid[ch]       = ($urandom_range(0, 3) == 0);
                bullet_x[10*ch +: 10]  = 10'(m_x + rx - 25);
                bullet_y[10*ch +: 10]  = 10'(m_y + ry - 40);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
